dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter onto a byte-wide memory; splits word/half/byte
// loads and stores into little-endian byte beats.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [2:0]        memop0,
  input  logic [31:0]       addr0,
  input  logic [31:0]       wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [2:0]        memop1,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata1,
  output logic              done0,
  output logic [31:0]       rdata0,
  output logic              err0,
  output logic              done1,
  output logic [31:0]       rdata1,
  output logic              err1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t              state, stateNext;
  logic                rrPtr, rrPtrNext;
  logic                gPort, gPortNext;
  logic                gWe, gWeNext;
  logic [2:0]          gOp, gOpNext;
  logic [ADDR_W-1:0]   gAddr, gAddrNext;
  logic [31:0]         gWdata, gWdataNext;
  logic [1:0]          beat, beatNext;
  logic [31:0]         cap, capNext;
  logic                sel;
  logic [31:0]         rdataNext;
  logic                done0Next, done1Next, err0Next, err1Next;
  logic [31:0]         rdata0Next, rdata1Next;
  logic                memEnNext, memWeNext;
  logic [ADDR_W-1:0]   memAddrNext;
  logic [7:0]          memWdataNext;

  // Address bits above ADDR_W are dropped on purpose.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{addr0[31:ADDR_W], addr1[31:ADDR_W]};

  function automatic logic [1:0] lastBeatOf(input logic [2:0] op);
    case (op)
      3'b000:         return 2'd3;
      3'b010, 3'b110: return 2'd1;
      default:        return 2'd0;
    endcase
  endfunction

  function automatic logic isWrite(input logic we, input logic [2:0] op);
    return we && (op == 3'b000 || op == 3'b001 || op == 3'b010);
  endfunction

  function automatic logic isErr(input logic we, input logic [2:0] op);
    return (op == 3'b011 || op == 3'b100 || op == 3'b111) ||
           (we && (op == 3'b101 || op == 3'b110));
  endfunction

  function automatic logic [31:0] formRdata(input logic we, input logic [2:0] op,
                                            input logic [31:0] c);
    if (we) return 32'd0;
    case (op)
      3'b000:  return c;
      3'b001:  return {{24{c[7]}}, c[7:0]};
      3'b010:  return {{16{c[15]}}, c[15:0]};
      3'b101:  return {24'd0, c[7:0]};
      3'b110:  return {16'd0, c[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  // Next-state, latched-field and registered-output computation.
  always_comb begin
    stateNext    = state;
    rrPtrNext    = rrPtr;
    gPortNext    = gPort;
    gWeNext      = gWe;
    gOpNext      = gOp;
    gAddrNext    = gAddr;
    gWdataNext   = gWdata;
    beatNext     = beat;
    capNext      = cap;
    sel          = 1'b0;
    rdataNext    = 32'd0;
    done0Next    = 1'b0;
    done1Next    = 1'b0;
    err0Next     = 1'b0;
    err1Next     = 1'b0;
    rdata0Next   = 32'd0;
    rdata1Next   = 32'd0;
    memEnNext    = 1'b0;
    memWeNext    = 1'b0;
    memAddrNext  = '0;
    memWdataNext = 8'd0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          sel          = (req0 && req1) ? rrPtr : req1;
          rrPtrNext    = ~sel;
          gPortNext    = sel;
          gWeNext      = sel ? we1 : we0;
          gOpNext      = sel ? memop1 : memop0;
          gAddrNext    = sel ? addr1[ADDR_W-1:0] : addr0[ADDR_W-1:0];
          gWdataNext   = sel ? wdata1 : wdata0;
          beatNext     = 2'd0;
          capNext      = 32'd0;
          memEnNext    = 1'b1;
          memWeNext    = isWrite(gWeNext, gOpNext);
          memAddrNext  = gAddrNext;
          memWdataNext = gWdataNext[7:0];
          stateNext    = XFER;
        end
      end
      XFER: begin
        if (!gWe) capNext[{beat, 3'b000} +: 8] = mem_rdata;
        if (beat == lastBeatOf(gOp)) begin
          rdataNext  = formRdata(gWe, gOp, capNext);
          done0Next  = ~gPort;
          done1Next  = gPort;
          err0Next   = ~gPort & isErr(gWe, gOp);
          err1Next   = gPort & isErr(gWe, gOp);
          rdata0Next = gPort ? 32'd0 : rdataNext;
          rdata1Next = gPort ? rdataNext : 32'd0;
          stateNext  = DONE;
        end else begin
          beatNext     = beat + 2'd1;
          memEnNext    = 1'b1;
          memWeNext    = isWrite(gWe, gOp);
          memAddrNext  = gAddr + ADDR_W'(beatNext);
          memWdataNext = gWdata[{beatNext, 3'b000} +: 8];
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State, latched fields and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rrPtr     <= 1'b0;
      gPort     <= 1'b0;
      gWe       <= 1'b0;
      gOp       <= 3'd0;
      gAddr     <= '0;
      gWdata    <= 32'd0;
      beat      <= 2'd0;
      cap       <= 32'd0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= 32'd0;
      rdata1    <= 32'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
    end else begin
      state     <= stateNext;
      rrPtr     <= rrPtrNext;
      gPort     <= gPortNext;
      gWe       <= gWeNext;
      gOp       <= gOpNext;
      gAddr     <= gAddrNext;
      gWdata    <= gWdataNext;
      beat      <= beatNext;
      cap       <= capNext;
      done0     <= done0Next;
      done1     <= done1Next;
      err0      <= err0Next;
      err1      <= err1Next;
      rdata0    <= rdata0Next;
      rdata1    <= rdata1Next;
      mem_en    <= memEnNext;
      mem_we    <= memWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, corner-case
// sequences and random transactions against a byte-array reference model.
module tb_dmem_arbiter;

  localparam int MEM_SZ = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [2:0]  memop0, memop1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        done0, err0, done1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem  [MEM_SZ];
  logic [7:0]  gmem [MEM_SZ];

  int total = 0;
  int bad = 0;
  int writes;
  logic [11:0] addrQ[$];

  dmem_arbiter #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .memop0(memop0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .memop1(memop1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .rdata0(rdata0), .err0(err0),
    .done1(done1), .rdata1(rdata1), .err1(err1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  // Byte memory behind the DUT plus a trace of each strobed beat.
  always @(posedge clk) begin
    if (mem_en) begin
      addrQ.push_back(mem_addr);
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        writes++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Reference: transaction semantics on a plain byte array.
  function automatic void refTxn(input bit we, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd,
                                 output bit er, output int lat);
    int n, base, idx;
    bit legal, wr;
    longint val;
    n = (op == 3'd0) ? 4 : (op == 3'd2 || op == 3'd6) ? 2 : 1;
    legal = (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd5 || op == 3'd6);
    wr = we && (op == 3'd0 || op == 3'd1 || op == 3'd2);
    er = !legal || (we && (op == 3'd5 || op == 3'd6));
    lat = n + 1;
    base = int'(a % 32'(MEM_SZ));
    val = 0;
    for (int k = 0; k < n; k++) begin
      idx = (base + k) % MEM_SZ;
      if (wr) gmem[idx] = 8'((wd >> (8 * k)) & 32'hFF);
      val += longint'(gmem[idx]) << (8 * k);
    end
    if (op == 3'd1 && val >= 128) val -= 256;
    if (op == 3'd2 && val >= 32768) val -= 65536;
    rd = (we || !legal) ? 32'd0 : 32'(val);
  endfunction

  task automatic runTxn(input int p, input bit we, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output bit er,
                        output int lat);
    logic other;
    writes = 0;
    addrQ.delete();
    if (p == 0) begin
      req0 = 1'b1; we0 = we; memop0 = op; addr0 = a; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; memop1 = op; addr1 = a; wdata1 = wd;
    end
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    // Scramble inputs to show the latched copy is what gets used.
    we0 = 1'($urandom); memop0 = 3'($urandom); addr0 = $urandom; wdata0 = $urandom;
    we1 = 1'($urandom); memop1 = 3'($urandom); addr1 = $urandom; wdata1 = $urandom;
    lat = 0; rd = 32'd0; er = 1'b0; other = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if ((p == 0) ? done0 : done1) begin
        lat = i;
        rd = (p == 0) ? rdata0 : rdata1;
        er = (p == 0) ? err0 : err1;
        other = (p == 0) ? done1 : done0;
        break;
      end
    end
    chk("other_done", 32'(other), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'({done0, done1}), 32'd0);
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expR;
    bit          expE;
    int          expLat;
    int          expWr;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [31:0] rd, mrd;
    bit er, mer;
    int lat, mlat, n, bothBad, mism, p;
    int dPort[$];
    int dCyc[$];
    bit we;
    logic [2:0] op;
    logic [31:0] a, wd;

    vt[0]  = '{0, 1'b1, 3'b000, 32'h010, 32'hA1B2C3D4, 32'h0,        1'b0, 5, 4};
    vt[1]  = '{0, 1'b0, 3'b000, 32'h010, 32'h0,        32'hA1B2C3D4, 1'b0, 5, 0};
    vt[2]  = '{1, 1'b1, 3'b001, 32'h020, 32'h00000080, 32'h0,        1'b0, 2, 1};
    vt[3]  = '{1, 1'b0, 3'b001, 32'h020, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0};
    vt[4]  = '{0, 1'b0, 3'b101, 32'h020, 32'h0,        32'h00000080, 1'b0, 2, 0};
    vt[5]  = '{0, 1'b1, 3'b010, 32'h020, 32'h00008001, 32'h0,        1'b0, 3, 2};
    vt[6]  = '{1, 1'b0, 3'b010, 32'h020, 32'h0,        32'hFFFF8001, 1'b0, 3, 0};
    vt[7]  = '{1, 1'b0, 3'b110, 32'h020, 32'h0,        32'h00008001, 1'b0, 3, 0};
    vt[8]  = '{0, 1'b1, 3'b110, 32'h020, 32'h0000BEEF, 32'h0,        1'b1, 3, 0};
    vt[9]  = '{0, 1'b0, 3'b000, 32'h020, 32'h0,        32'h00008001, 1'b0, 5, 0};
    vt[10] = '{0, 1'b0, 3'b011, 32'h030, 32'h0,        32'h0,        1'b1, 2, 0};
    vt[11] = '{1, 1'b1, 3'b100, 32'h030, 32'hFFFFFFFF, 32'h0,        1'b1, 2, 0};
    vt[12] = '{0, 1'b1, 3'b111, 32'h031, 32'h00000055, 32'h0,        1'b1, 2, 0};
    vt[13] = '{1, 1'b0, 3'b000, 32'h030, 32'h0,        32'h0,        1'b0, 5, 0};

    for (int i = 0; i < MEM_SZ; i++) begin
      mem[i] = 8'd0;
      gmem[i] = 8'd0;
    end
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; memop0 = 3'd0; addr0 = 32'd0; wdata0 = 32'd0;
    req1 = 1'b0; we1 = 1'b0; memop1 = 3'd0; addr1 = 32'd0; wdata1 = 32'd0;
    #1;
    chk("reset_outputs", 32'({done0, done1, err0, err1, mem_en, mem_we}), 32'd0);
    chk("reset_data", rdata0 | rdata1 | 32'(mem_addr) | 32'(mem_wdata), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      refTxn(vt[i].we, vt[i].op, vt[i].addr, vt[i].wdata, mrd, mer, mlat);
      runTxn(vt[i].port, vt[i].we, vt[i].op, vt[i].addr, vt[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].expR);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].expE));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].expLat));
      chk($sformatf("vec%0d_writes", i), 32'(writes), 32'(vt[i].expWr));
    end
    chk("word_bytes", {mem[19], mem[18], mem[17], mem[16]}, 32'hA1B2C3D4);

    // Wrap-around store, then load through an address with junk upper bits.
    refTxn(1'b1, 3'b000, 32'h00000FFE, 32'h11223344, mrd, mer, mlat);
    runTxn(1, 1'b1, 3'b000, 32'h00000FFE, 32'h11223344, rd, er, lat);
    chk("wrap_beats", 32'(addrQ.size()), 32'd4);
    if (addrQ.size() == 4) begin
      chk("wrap_a0", 32'(addrQ[0]), 32'hFFE);
      chk("wrap_a1", 32'(addrQ[1]), 32'hFFF);
      chk("wrap_a2", 32'(addrQ[2]), 32'h000);
      chk("wrap_a3", 32'(addrQ[3]), 32'h001);
    end
    refTxn(1'b0, 3'b000, 32'hABCDEFFE, 32'h0, mrd, mer, mlat);
    runTxn(0, 1'b0, 3'b000, 32'hABCDEFFE, 32'h0, rd, er, lat);
    chk("wrap_load", rd, 32'h11223344);

    // Reset abort mid word store, after beat 1 has been written.
    req0 = 1'b1; we0 = 1'b1; memop0 = 3'b000; addr0 = 32'h040; wdata0 = 32'hDEADBEEF;
    @(posedge clk);
    #1 req0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", 32'({done0, done1, err0, err1, mem_en, mem_we}) | 32'(mem_addr)
        | 32'(mem_wdata) | rdata0 | rdata1, 32'd0);
    chk("abort_b0", 32'(mem[64]), 32'hEF);
    chk("abort_b1", 32'(mem[65]), 32'hBE);
    chk("abort_b2", 32'(mem[66]), 32'h00);
    chk("abort_b3", 32'(mem[67]), 32'h00);
    gmem[64] = 8'hEF;
    gmem[65] = 8'hBE;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0 || done1) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);

    // Contention: both requesters held high straight out of reset.
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; memop0 = 3'b001; addr0 = 32'h020;
    req1 = 1'b1; we1 = 1'b0; memop1 = 3'b001; addr1 = 32'h021;
    @(negedge clk);
    rst = 1'b0;
    bothBad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done0 && done1) bothBad++;
      if (done0) begin dPort.push_back(0); dCyc.push_back(c); end
      if (done1) begin dPort.push_back(1); dCyc.push_back(c); end
      if (dPort.size() >= 4) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("rr_last_pulse", 32'({done0, done1}), 32'd0);
    chk("rr_both", 32'(bothBad), 32'd0);
    chk("rr_count", 32'(dPort.size()), 32'd4);
    if (dPort.size() >= 4) begin
      chk("rr_first_cyc", 32'(dCyc[0]), 32'd2);
      for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 32'(dPort[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) chk($sformatf("rr_gap%0d", i), 32'(dCyc[i] - dCyc[i-1]), 32'd3);
    end

    // Random transactions against the reference model.
    for (int i = 0; i < 150; i++) begin
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      a[11:0] = ($urandom_range(0, 3) == 0) ? 12'(12'hFFA + $urandom_range(0, 5))
                                            : 12'(12'h0F0 + $urandom_range(0, 31));
      wd = $urandom;
      refTxn(we, op, a, wd, mrd, mer, mlat);
      runTxn(p, we, op, a, wd, rd, er, lat);
      chk($sformatf("rnd%0d_rdata", i), rd, mrd);
      chk($sformatf("rnd%0d_err", i), 32'(er), 32'(mer));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(mlat));
    end

    mism = 0;
    for (int i = 0; i < MEM_SZ; i++) if (mem[i] !== gmem[i]) mism++;
    chk("mem_image", 32'(mism), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
